// File: rtl/mips_instr_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and streams them into
// consecutive instruction-memory addresses during a load session.
module mips_instr_encoder #(
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   // Handshake: an instruction transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready is a pure function of state, never of in_valid.
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [3:0]        op_sel,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   instr_count,
   output logic              err_illegal,
   output logic              err_full
);

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              ill_q, ill_d;
   logic              full_q, full_d;

   logic              enc_legal;
   logic [31:0]       enc_word;
   logic [ADDR_W:0]   count_inc;

   always_comb begin
      enc_legal = 1'b1;
      enc_word  = '0;
      case (op_sel)
         4'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
         4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
         4'd2:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
         4'd3:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
         4'd4:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
         4'd5:    enc_word = {6'b001000, rs, rt, imm};
         4'd6:    enc_word = {6'b100011, rs, rt, imm};
         4'd7:    enc_word = {6'b101011, rs, rt, imm};
         4'd8:    enc_word = {6'b000100, rs, rt, imm};
         4'd9:    enc_word = {6'b000010, target};
         default: enc_legal = 1'b0;
      endcase
   end

   assign count_inc = count_q + 1'b1;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      ill_d   = ill_q;
      full_d  = full_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_LOAD;
               addr_d  = BASE;
               count_d = '0;
               ill_d   = 1'b0;
               full_d  = 1'b0;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               if (enc_legal) begin
                  we_d    = 1'b1;
                  waddr_d = addr_q;
                  wdata_d = enc_word;
                  addr_d  = addr_q + 1'b1;
                  count_d = count_inc;
               end else begin
                  ill_d = 1'b1;
               end
               // in_last wins over the full condition when both land together
               if (in_last) begin
                  state_d = S_DONE;
               end else if (enc_legal && (count_inc == FULL_CNT)) begin
                  state_d = S_DONE;
                  full_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= BASE;
         count_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= BASE;
         wdata_q <= '0;
         ill_q   <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         ill_q   <= ill_d;
         full_q  <= full_d;
      end
   end

   assign in_ready    = (state_q == S_LOAD);
   assign busy        = (state_q == S_LOAD);
   assign done        = (state_q == S_DONE);
   assign imem_we     = we_q;
   assign imem_addr   = waddr_q;
   assign imem_wdata  = wdata_q;
   assign instr_count = count_q;
   assign err_illegal = ill_q;
   assign err_full    = full_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: a 64-word and a 4-word instance share one
// stimulus stream and are checked every cycle against a session-level model.
module tb_mips_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, in_valid, in_last;
   logic [3:0]  op_sel;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;

   logic        rdy0, we0, busy0, done0, ill0, full0;
   logic [5:0]  addr0;
   logic [31:0] wdata0;
   logic [6:0]  cnt0;
   logic        rdy1, we1, busy1, done1, ill1, full1;
   logic [1:0]  addr1;
   logic [31:0] wdata1;
   logic [2:0]  cnt1;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy0),
      .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .target(target), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
      .busy(busy0), .done(done0), .instr_count(cnt0), .err_illegal(ill0), .err_full(full0));

   mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy1),
      .in_last(in_last), .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .target(target), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
      .busy(busy1), .done(done1), .instr_count(cnt1), .err_illegal(ill1), .err_full(full1));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [5:0] r_funct [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
   logic [5:0] i_opc   [4] = '{6'h08, 6'h23, 6'h2B, 6'h04};
   int         dep     [2] = '{64, 4};

   int   m_st   [2] = '{0, 0};   // 0 idle, 1 loading, 2 finished
   int   m_addr [2] = '{0, 0};
   int   m_cnt  [2] = '{0, 0};
   bit   m_ill  [2] = '{0, 0};
   bit   m_full [2] = '{0, 0};
   bit   m_we   [2] = '{0, 0};
   logic [37:0] exp_q0[$];
   logic [37:0] exp_q1[$];
   logic [37:0] mw;

   function automatic logic [31:0] model_enc(input int op, input logic [4:0] s, t, d,
                                             input logic [15:0] im, input logic [25:0] tg);
      if (op < 5)      return {6'd0, s, t, d, 5'd0, r_funct[op]};
      else if (op < 9) return {i_opc[op-5], s, t, im};
      else             return {6'b000010, tg};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int id = 0; id < 2; id++) begin
            m_st[id] <= 0; m_addr[id] <= 0; m_cnt[id] <= 0;
            m_ill[id] <= 1'b0; m_full[id] <= 1'b0; m_we[id] <= 1'b0;
         end
         exp_q0.delete();
         exp_q1.delete();
      end else begin
         for (int id = 0; id < 2; id++) begin
            m_we[id] <= 1'b0;
            if (m_st[id] != 1) begin
               if (start) begin
                  m_st[id] <= 1; m_addr[id] <= 0; m_cnt[id] <= 0;
                  m_ill[id] <= 1'b0; m_full[id] <= 1'b0;
               end
            end else if (in_valid) begin
               if (op_sel < 4'd10) begin
                  mw = {6'(m_addr[id]), model_enc(int'(op_sel), rs, rt, rd, imm, target)};
                  if (id == 0) exp_q0.push_back(mw);
                  else         exp_q1.push_back(mw);
                  m_we[id]   <= 1'b1;
                  m_addr[id] <= (m_addr[id] + 1) % dep[id];
                  m_cnt[id]  <= m_cnt[id] + 1;
               end else begin
                  m_ill[id] <= 1'b1;
               end
               if (in_last) m_st[id] <= 2;
               else if (op_sel < 4'd10 && m_cnt[id] + 1 == dep[id]) begin
                  m_st[id] <= 2; m_full[id] <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   task automatic cmp(input int id, input logic rdy, bsy, dn, input logic [6:0] cnt,
                      input logic il, fl, we, input logic [5:0] ad, input logic [31:0] wd);
      logic [37:0] e;
      chk($sformatf("d%0d.in_ready", id), rdy, m_st[id] == 1);
      chk($sformatf("d%0d.busy", id), bsy, m_st[id] == 1);
      chk($sformatf("d%0d.done", id), dn, m_st[id] == 2);
      chk($sformatf("d%0d.instr_count", id), cnt, m_cnt[id]);
      chk($sformatf("d%0d.err_illegal", id), il, m_ill[id]);
      chk($sformatf("d%0d.err_full", id), fl, m_full[id]);
      chk($sformatf("d%0d.imem_we", id), we, m_we[id]);
      if (m_we[id]) begin
         e = '0;
         if (id == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
         if (id == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
         chk($sformatf("d%0d.imem_addr", id), ad, e[37:32]);
         chk($sformatf("d%0d.imem_wdata", id), wd, e[31:0]);
      end
   endtask

   always @(negedge clk) begin
      cmp(0, rdy0, busy0, done0, cnt0, ill0, full0, we0, addr0, wdata0);
      cmp(1, rdy1, busy1, done1, {4'd0, cnt1}, ill1, full1, we1, {4'd0, addr1}, wdata1);
   end

   // Log of dut0 writes, pinned against hand-computed words after each session.
   logic [31:0] wr_d[$];
   logic [5:0]  wr_a[$];
   logic [31:0] lit_q[$];

   always @(negedge clk) begin
      if (we0 === 1'b1) begin
         wr_d.push_back(wdata0);
         wr_a.push_back(addr0);
      end
   end

   task automatic check_lits(input string name);
      chk({name, ".writes"}, wr_d.size(), lit_q.size());
      for (int i = 0; i < wr_d.size() && i < lit_q.size(); i++) begin
         chk($sformatf("%s.data%0d", name, i), wr_d[i], lit_q[i]);
         chk($sformatf("%s.addr%0d", name, i), wr_a[i], i);
      end
      wr_d.delete();
      wr_a.delete();
      lit_q.delete();
   endtask

   // ---------------- drivers ----------------
   task automatic idle(input int n);
      repeat (n) begin
         op_sel = 4'($urandom_range(0, 15));
         rs = 5'($urandom_range(0, 31));
         imm = 16'($urandom_range(0, 65535));
         @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [4:0] s, t, d,
                       input logic [15:0] im, input logic [25:0] tg, input logic last);
      in_valid = 1'b1; op_sel = op; rs = s; rt = t; rd = d; imm = im; target = tg; in_last = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic reset_lits(input string name);
      chk({name, ".d0.we"}, we0, 1'b0);
      chk({name, ".d0.addr"}, addr0, 6'd0);
      chk({name, ".d0.wdata"}, wdata0, 32'd0);
      chk({name, ".d0.ready"}, rdy0, 1'b0);
      chk({name, ".d0.busy"}, busy0, 1'b0);
      chk({name, ".d0.done"}, done0, 1'b0);
      chk({name, ".d0.count"}, cnt0, 7'd0);
      chk({name, ".d0.flags"}, {ill0, full0}, 2'b00);
      chk({name, ".d1.we"}, we1, 1'b0);
      chk({name, ".d1.ready"}, rdy1, 1'b0);
      chk({name, ".d1.done"}, done1, 1'b0);
      chk({name, ".d1.count"}, cnt1, 3'd0);
      chk({name, ".d1.flags"}, {ill1, full1}, 2'b00);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
      repeat (3) @(negedge clk);
      reset_lits("por");
      rst_n = 1'b1;
      idle(1);

      // single ADD with in_last
      pulse_start();
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
      idle(2);
      lit_q = '{32'h00221820};
      check_lits("t1");
      chk("t1.done", done0, 1'b1);
      chk("t1.count", cnt0, 7'd1);

      // back-to-back mix; the 4-word instance fills on BEQ
      pulse_start();
      send(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
      send(4'd4, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
      send(4'd6, 5'd4, 5'd5, 5'd0, 16'h0010, 26'd0, 1'b0);
      send(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0);
      send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'd4, 1'b1);
      idle(2);
      lit_q = '{32'h00221822, 32'h0022182A, 32'h8C850010, 32'h1022FFFF, 32'h08000004};
      check_lits("t2");
      chk("t2.count", cnt0, 7'd5);
      chk("t2.d1.full", full1, 1'b1);
      chk("t2.d1.count", cnt1, 3'd4);

      // illegal op between two ADDs
      pulse_start();
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
      send(4'd12, 5'd7, 5'd7, 5'd7, 16'd7, 26'd7, 1'b0);
      send(4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b1);
      idle(2);
      lit_q = '{32'h00221820, 32'h00853020};
      check_lits("t3");
      chk("t3.err_illegal", ill0, 1'b1);
      chk("t3.count", cnt0, 7'd2);

      // five ADDIs, no in_last: small instance fills after the fourth
      pulse_start();
      for (int k = 1; k <= 5; k++) send(4'd5, 5'd1, 5'd2, 5'd0, 16'(k), 26'd0, 1'b0);
      chk("t4.d1.ready", rdy1, 1'b0);
      chk("t4.d1.done", done1, 1'b1);
      chk("t4.d1.full", full1, 1'b1);
      chk("t4.d1.count", cnt1, 3'd4);
      chk("t4.d0.busy", busy0, 1'b1);
      send(4'd15, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
      idle(2);
      lit_q = '{32'h20220001, 32'h20220002, 32'h20220003, 32'h20220004, 32'h20220005};
      check_lits("t4");
      chk("t4.d0.done", done0, 1'b1);
      chk("t4.d0.flags", {ill0, full0}, 2'b10);
      chk("t4.d0.count", cnt0, 7'd5);

      // asynchronous reset mid-session, then reload from address 0
      pulse_start();
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
      send(4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b0);
      #2 rst_n = 1'b0;
      #1 reset_lits("mid");
      lit_q = '{32'h00221820, 32'h00853020};
      check_lits("t5a");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      send(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
      idle(2);
      lit_q = '{32'h00221824};
      check_lits("t5b");

      // gapped valid and a start pulse while loading
      pulse_start();
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
      idle(1);
      send(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
      pulse_start();
      send(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
      idle(2);
      lit_q = '{32'h00221820, 32'h00221822, 32'h00221824};
      check_lits("t6");
      chk("t6.count", cnt0, 7'd3);

      chk("end.q0_empty", exp_q0.size(), 0);
      chk("end.q1_empty", exp_q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Instruction encoder and program loader for the single-cycle MIPS core. It accepts symbolic instructions (operation select plus register, immediate and target fields) over a valid/ready handshake. It packs each one into the 32-bit MIPS word that the control unit decodes, and writes the words to consecutive instruction-memory addresses. It runs before the core is released, and gives benches and boot logic one source of truth for the opcode/funct encoding.

## Interface
- ADDR_W, 6: instruction-memory word-address width; depth = 2^ADDR_W.
- BASE_ADDR, 0: first word address written after `start`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction this cycle.
- in_last  in  1  marks the final instruction of the program.
- op_sel  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 J; 10–15 illegal.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate/offset (I-type).
- target  in  26  jump target (J).
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session in progress.
- done  out  1  session finished (level).
- instr_count  out  ADDR_W+1  words written this session.
- err_illegal  out  1  sticky: an illegal op_sel was accepted.
- err_full  out  1  sticky: memory filled before in_last.

## Operation
- States:
  - IDLE: in_ready=0. `start` → LOAD.
  - LOAD: in_ready=1. A handshake (in_valid & in_ready) is accepted.
  - DONE: in_ready=0. `start` → LOAD.
- Entering LOAD:
  - write address = BASE_ADDR, instr_count=0;
  - err_illegal and err_full cleared;
  - done=0.
- `start` while in LOAD is ignored.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type: {opcode, rs, rt, imm}. opcode: ADDI 001000, LW 100011, SW 101011, BEQ 000100.
  - J: {000010, target}.
- Accepted legal instruction:
  - registered into imem_wdata, with imem_addr = current address;
  - imem_we=1 for exactly one cycle;
  - address increments modulo 2^ADDR_W; instr_count increments.
- Accepted illegal op_sel:
  - no write; address and count unchanged;
  - err_illegal set.
  - If in_last is also high, the session still ends (→ DONE).
- Session end:
  - Accepted in_last → DONE after its write (or immediately, if illegal).
  - A write to the last address (instr_count reaching 2^ADDR_W − (BASE_ADDR)) without in_last → DONE with err_full=1.
- busy = (state==LOAD). done = (state==DONE).

## Timing
- Reset (asynchronous, rst_n=0):
  - state IDLE;
  - in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0;
  - busy=0, done=0, instr_count=0, err_illegal=0, err_full=0.
- `start` sampled at edge N → in_ready=1 from cycle N+1.
- Handshake at edge N → imem_we/addr/wdata valid during cycle N+1. Latency is 1 cycle.
- Throughput: one instruction per cycle; back-to-back handshakes produce back-to-back writes.
- in_last handshake at edge N:
  - in_ready=0 and done=1 from cycle N+1, coincident with the final imem_we.
  - instr_count is final in cycle N+1.
- Full condition: the handshake that fills memory causes in_ready=0, done=1 and err_full=1 in the following cycle. No further writes occur.
- in_ready does not depend combinationally on in_valid.
- Field inputs are sampled only on a handshake.
- Reset asserted mid-session:
  - imem_we drops immediately;
  - all flags clear;
  - the partial program is abandoned.

## Test plan
- Reset, `start`, then ADD rs=1 rt=2 rd=3 with in_last → one write: addr 0, data 0x00221820; done=1 and instr_count=1 in the same cycle.
- Back-to-back SUB, SLT (rs=1 rt=2 rd=3), LW (rs=4 rt=5 imm=0x0010), BEQ (rs=1 rt=2 imm=0xFFFF), J (target=4, last):
  - data 0x00221822, 0x0022182A, 0x8C850010, 0x1022FFFF, 0x08000004;
  - addr 0–4 on consecutive cycles; count=5.
- op_sel=12 mid-stream between two ADDs:
  - err_illegal=1;
  - only two writes, at addr 0 and 1;
  - session continues.
- ADDR_W=2: present 5 instructions with no in_last:
  - writes at addr 0–3;
  - err_full=1, done=1; in_ready=0 after the fourth handshake.
- rst_n low during LOAD after 2 writes:
  - all outputs at reset values asynchronously;
  - a new `start` writes again from addr 0.
- in_valid toggling 1/0 each cycle, and `start` pulsed during LOAD:
  - writes occur only on handshake cycles;
  - the mid-session `start` does not reset the address.
